// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: register offsets, bus FSM states,
// default sizes and the Gray-code position helper.
package quad_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int FILTER_LEN_DEF = 4;
  localparam int MOVE_W         = 12;

  localparam logic [1:0] OFF_POS  = 2'd0;
  localparam logic [1:0] OFF_STAT = 2'd1;
  localparam logic [1:0] OFF_CLR  = 2'd2;
  localparam logic [1:0] OFF_ERR  = 2'd3;

  localparam int ST_MOVING = 0;
  localparam int ST_DIR    = 1;
  localparam int ST_ERR    = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LATCH    = 2'd1,
    ACK      = 2'd2,
    WAIT_REL = 2'd3
  } busState_t;

  // Position of an {A,B} pair within the CW cycle 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] grayIdx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Processor-side register bus of the quadrature decoder: 12-bit address, active-low
// strobe, ready handshake and driven read data.
interface quad_decoder_if import quad_pkg::*; #(parameter int CNT_W = CNT_W_DEF);

  logic [11:0]      add;
  logic             strobe;
  logic             ready;
  logic [CNT_W-1:0] data_out;
  logic             data_oe;

  modport master (output add, output strobe, input ready, input data_out, input data_oe);
  modport slave  (input add, input strobe, output ready, output data_out, output data_oe);

endinterface

// File: rtl/quad_chan_sync.sv
// One encoder channel: two-flop synchroniser on negedge clk, plus a stability filter
// when QDEC_GLITCH_FILTER_EN is defined. lvlVld rises once lvl reflects the real input.
module quad_chan_sync import quad_pkg::*;
`ifdef QDEC_GLITCH_FILTER_EN
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic lvl,
  output logic lvlVld
);

  logic s1_p0, s2_p1;
  logic vld_p0, vld_p1;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_p0  <= 1'b0;
      s2_p1  <= 1'b0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      s1_p0  <= raw;
      s2_p1  <= s1_p0;
      vld_p0 <= 1'b1;
      vld_p1 <= vld_p0;
    end
  end

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int FC_W = $clog2(FILTER_LEN + 1);

  logic [FC_W-1:0] fltCnt;
  logic            fltLvl_p2;
  logic            fltVld_p2;

  // stage p2: first valid sample is taken as-is, later changes need FILTER_LEN agreeing samples
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fltCnt    <= '0;
      fltLvl_p2 <= 1'b0;
      fltVld_p2 <= 1'b0;
    end else if (vld_p1) begin
      if (!fltVld_p2) begin
        fltLvl_p2 <= s2_p1;
        fltVld_p2 <= 1'b1;
        fltCnt    <= '0;
      end else if (s2_p1 == fltLvl_p2) begin
        fltCnt <= '0;
      end else if (fltCnt == FC_W'(FILTER_LEN - 1)) begin
        fltLvl_p2 <= s2_p1;
        fltCnt    <= '0;
      end else begin
        fltCnt <= fltCnt + FC_W'(1);
      end
    end
  end

  assign lvl    = fltLvl_p2;
  assign lvlVld = fltVld_p2;
`else
  assign lvl    = s2_p1;
  assign lvlVld = vld_p1;
`endif

endmodule

// File: rtl/quad_decoder.sv
// 4x quadrature decoder with position/direction/error registers on the 12-bit strobe bus.
// Optional glitch filter on both channels: define QDEC_GLITCH_FILTER_EN.
module quad_decoder import quad_pkg::*; #(
  parameter int          CNT_W     = CNT_W_DEF,
  parameter logic [11:0] BASE_ADDR = 12'h110
`ifdef QDEC_GLITCH_FILTER_EN
  , parameter int        FILTER_LEN = FILTER_LEN_DEF
`endif
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           chA,
  input  logic           chB,
  quad_decoder_if.slave  bus,
  output logic           irq_n,
  output logic           dir_cw
);

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic lvlA, lvlB, vldA, vldB;

`ifdef QDEC_GLITCH_FILTER_EN
  quad_chan_sync #(.FILTER_LEN(FILTER_LEN)) uSyncA (.clk(clk), .rst_n(rst_n), .raw(chA), .lvl(lvlA), .lvlVld(vldA));
  quad_chan_sync #(.FILTER_LEN(FILTER_LEN)) uSyncB (.clk(clk), .rst_n(rst_n), .raw(chB), .lvl(lvlB), .lvlVld(vldB));
`else
  quad_chan_sync uSyncA (.clk(clk), .rst_n(rst_n), .raw(chA), .lvl(lvlA), .lvlVld(vldA));
  quad_chan_sync uSyncB (.clk(clk), .rst_n(rst_n), .raw(chB), .lvl(lvlB), .lvlVld(vldB));
`endif

  logic [1:0]       curAb, prevAb, delta;
  logic             primed, sampleVld, stepCw, stepCcw, illegal;
  logic [CNT_W-1:0] pos, rdData;
  logic [7:0]       errCnt;
  logic             errFlag, moving;
  logic [MOVE_W-1:0] movCnt;
  busState_t        state;
  logic [1:0]       offQ;
  logic [11:0]      addOff;
  logic             inRange, clrPos, errClr;

  assign curAb     = {lvlA, lvlB};
  assign sampleVld = vldA & vldB;
  assign delta     = grayIdx(curAb) - grayIdx(prevAb);
  assign stepCw    = primed & sampleVld & (delta == 2'd1);
  assign stepCcw   = primed & sampleVld & (delta == 2'd3);
  assign illegal   = primed & sampleVld & (delta == 2'd2);

  assign clrPos = (state == LATCH) && (offQ == OFF_CLR);
  assign errClr = (state == LATCH) && (offQ == OFF_ERR);

  // decode stage: the first valid sample only primes prevAb so a resting encoder never counts
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prevAb  <= 2'b00;
      primed  <= 1'b0;
      pos     <= '0;
      dir_cw  <= 1'b0;
      irq_n   <= 1'b1;
      errCnt  <= 8'd0;
      errFlag <= 1'b0;
      movCnt  <= '0;
      moving  <= 1'b0;
    end else begin
      irq_n <= ~(stepCw | stepCcw);
      if (sampleVld) begin
        prevAb <= curAb;
        primed <= 1'b1;
      end
      if (clrPos)       pos <= '0;
      else if (stepCw)  pos <= pos + CNT_W'(1);
      else if (stepCcw) pos <= pos - CNT_W'(1);
      if (stepCw | stepCcw) dir_cw <= stepCw;
      if (errClr) begin
        errCnt  <= illegal ? 8'd1 : 8'd0;
        errFlag <= illegal;
      end else if (illegal) begin
        errCnt  <= satInc(errCnt);
        errFlag <= 1'b1;
      end
      if (stepCw | stepCcw) begin
        movCnt <= '0;
        moving <= 1'b1;
      end else if (moving) begin
        if (&movCnt) moving <= 1'b0;
        movCnt <= movCnt + MOVE_W'(1);
      end
    end
  end

  always_comb begin
    rdData = '0;
    case (offQ)
      OFF_POS: rdData = pos;
      OFF_STAT: begin
        rdData[ST_MOVING] = moving;
        rdData[ST_DIR]    = dir_cw;
        rdData[ST_ERR]    = errFlag;
      end
      OFF_ERR: rdData[7:0] = errCnt;
      default: ;
    endcase
  end

  assign addOff  = bus.add - BASE_ADDR;
  assign inRange = addOff < 12'd4;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      offQ         <= 2'd0;
      bus.ready    <= 1'b1;
      bus.data_out <= '0;
      bus.data_oe  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!bus.strobe && inRange) begin
          offQ      <= addOff[1:0];
          bus.ready <= 1'b0;
          state     <= LATCH;
        end
        LATCH: begin
          bus.data_out <= rdData;
          bus.data_oe  <= (offQ != OFF_CLR);
          bus.ready    <= 1'b1;
          state        <= ACK;
        end
        ACK: state <= WAIT_REL;
        WAIT_REL: if (bus.strobe) begin
          bus.data_oe <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Randomized encoder walk and directed bus scenarios for quad_decoder, checked against a
// sequence-index model of the encoder (position, direction, error count, status).
module tb_quad_decoder;
  import quad_pkg::*;

  localparam int          CNT_W = 16;
  localparam logic [11:0] BASE  = 12'h110;
`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT = 3 + FILTER_LEN_DEF;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chA = 1'b1;
  logic chB = 1'b1;
  logic irq_n, dir_cw;

  quad_decoder_if #(.CNT_W(CNT_W)) bus ();

  quad_decoder #(.CNT_W(CNT_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .chA(chA), .chB(chB),
    .bus(bus), .irq_n(irq_n), .dir_cw(dir_cw)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int irqSeen = 0;

  logic [1:0]  seqAb [4];
  int          encIdx;
  logic [15:0] expPos;
  logic        expDir, expErrFlag, expMoving;
  int          expErr;

  always @(posedge clk) begin
    #1;
    if (rst_n && !irq_n) irqSeen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required end of test");
    $fatal(1);
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] statusExp();
    return {13'd0, expErrFlag, expDir, expMoving};
  endfunction

  // kind: 0 none, 1 CW, 2 CCW, 3 illegal (both bits flip)
  task automatic driveEnc(input int kind);
    case (kind)
      1: begin encIdx = (encIdx + 1) % 4; expPos = expPos + 16'd1; expDir = 1'b1; expMoving = 1'b1; end
      2: begin encIdx = (encIdx + 3) % 4; expPos = expPos - 16'd1; expDir = 1'b0; expMoving = 1'b1; end
      3: begin encIdx = (encIdx + 2) % 4; expErr = (expErr < 255) ? expErr + 1 : 255; expErrFlag = 1'b1; end
      default: ;
    endcase
    {chA, chB} = seqAb[encIdx];
  endtask

  task automatic encStep(input int kind);
    int lowCnt = 0;
    int firstLow = 0;
    @(posedge clk);
    driveEnc(kind);
    for (int k = 1; k <= LAT + 4; k++) begin
      @(posedge clk); #1;
      if (!irq_n) begin
        lowCnt++;
        if (firstLow == 0) firstLow = k;
      end
    end
    if (kind == 1 || kind == 2) begin
      checkEq("irqLatency", firstLow, LAT);
      checkEq("irqWidth", lowCnt, 1);
    end else begin
      checkEq("irqNone", lowCnt, 0);
    end
  endtask

  task automatic busAccess(input logic [11:0] a, input int hold, output logic [15:0] d);
    logic got = 1'b0;
    logic oeExp;
    int   bad = 0;
    oeExp = (a != BASE + 12'd2);
    @(posedge clk);
    bus.add = a;
    bus.strobe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (!bus.ready) begin got = 1'b1; break; end
    end
    checkEq("readyLow", got, 1'b1);
    @(posedge clk); #1;
    checkEq("readyBack", bus.ready, 1'b1);
    checkEq("dataOe", bus.data_oe, oeExp);
    d = bus.data_out;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!bus.ready || bus.data_oe !== oeExp || bus.data_out !== d) bad++;
    end
    checkEq("holdStable", bad, 0);
    @(posedge clk);
    bus.strobe = 1'b1;
    @(posedge clk); #1;
    checkEq("oeRelease", bus.data_oe, 1'b0);
    bus.add = 12'h000;
  endtask

  initial begin
    logic [15:0] d, old;
    int          pre, bad;

    seqAb[0] = 2'b00; seqAb[1] = 2'b01; seqAb[2] = 2'b11; seqAb[3] = 2'b10;
    encIdx = 2; expPos = 16'd0; expDir = 1'b0; expErr = 0; expErrFlag = 1'b0; expMoving = 1'b0;
    bus.add = 12'h000;
    bus.strobe = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkEq("rstReady", bus.ready, 1'b1);
    checkEq("rstDataOe", bus.data_oe, 1'b0);
    checkEq("rstDataOut", bus.data_out, 16'h0000);
    checkEq("rstIrq", irq_n, 1'b1);
    checkEq("rstDir", dir_cw, 1'b0);
    @(posedge clk);
    rst_n = 1'b1;

    // priming with the encoder resting at 11
    repeat (10) @(posedge clk);
    #1;
    checkEq("primeIrq", irqSeen, 0);
    busAccess(BASE + 12'd0, 0, d); checkEq("primePos", d, 16'h0000);
    busAccess(BASE + 12'd3, 0, d); checkEq("primeErr", d, 16'h0000);
    busAccess(BASE + 12'd1, 0, d); checkEq("primeStat", d, statusExp());

    for (int i = 0; i < 8; i++) begin
      encStep(1);
      repeat (2) @(posedge clk);
    end
    busAccess(BASE + 12'd0, 0, d); checkEq("cwPos", d, expPos);
    checkEq("cwDir", dir_cw, 1'b1);
    busAccess(BASE + 12'd1, 0, d); checkEq("cwStat", d, statusExp());

    busAccess(BASE + 12'd2, 0, d); expPos = 16'd0;
    busAccess(BASE + 12'd0, 0, d); checkEq("clrPos", d, 16'h0000);
    encStep(2);
    busAccess(BASE + 12'd0, 0, d); checkEq("wrapDown", d, 16'hFFFF);
    checkEq("ccwDir", dir_cw, 1'b0);
    encStep(1);
    busAccess(BASE + 12'd0, 0, d); checkEq("wrapUp", d, 16'h0000);

    for (int i = 0; i < 3; i++) encStep(3);
    busAccess(BASE + 12'd0, 0, d); checkEq("illPos", d, expPos);
    busAccess(BASE + 12'd1, 0, d); checkEq("illStat", d, statusExp());
    busAccess(BASE + 12'd3, 0, d); checkEq("errCnt3", d, 16'd3);
    expErr = 0; expErrFlag = 1'b0;
    busAccess(BASE + 12'd3, 0, d); checkEq("errCleared", d, 16'd0);
    busAccess(BASE + 12'd1, 0, d); checkEq("statErrClr", d, statusExp());

    // long strobe: exactly one access; out-of-range address ignored
    pre = irqSeen;
    busAccess(BASE + 12'd0, 20, d); checkEq("holdPos", d, expPos);
    @(posedge clk);
    bus.add = 12'h10C;
    bus.strobe = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!bus.ready || bus.data_oe) bad++;
    end
    checkEq("ignoredAddr", bad, 0);
    bus.strobe = 1'b1;
    bus.add = 12'h000;

    repeat (40) encStep($urandom_range(0, 3));
    busAccess(BASE + 12'd0, 0, d); checkEq("rndPos", d, expPos);
    checkEq("rndDir", dir_cw, expDir);
    busAccess(BASE + 12'd1, 0, d); checkEq("rndStat", d, statusExp());
    busAccess(BASE + 12'd3, 0, d); checkEq("rndErr", d, expErr);
    expErr = 0; expErrFlag = 1'b0;

    // clear coincident with a CW step: clear wins, irq still pulses
    encStep(1); encStep(1);
    pre = irqSeen;
    @(posedge clk);
    driveEnc(1);
    busAccess(BASE + 12'd2, 0, d);
    expPos = 16'd0;
    repeat (LAT + 2) @(posedge clk);
    checkEq("clrStepIrq", irqSeen - pre, 1);
    busAccess(BASE + 12'd0, 0, d); checkEq("clrStepPos", d, 16'h0000);

    // pos read coincident with a step returns the pre-step value
    encStep(1);
    old = expPos;
    @(posedge clk);
    driveEnc(1);
    busAccess(BASE + 12'd0, 0, d); checkEq("readOldPos", d, old);
    busAccess(BASE + 12'd0, 0, d); checkEq("readNewPos", d, expPos);

    // err read-clear coincident with an illegal jump
    encStep(3);
    old = 16'(expErr);
    @(posedge clk);
    driveEnc(3);
    busAccess(BASE + 12'd3, 0, d); checkEq("errClrOld", d, old);
    expErr = 1; expErrFlag = 1'b1;
    busAccess(BASE + 12'd1, 0, d); checkEq("errClrStat", d, statusExp());
    busAccess(BASE + 12'd3, 0, d); checkEq("errClrCnt", d, 16'd1);
    expErr = 0; expErrFlag = 1'b0;

    for (int i = 0; i < 260; i++) encStep(3);
    busAccess(BASE + 12'd3, 0, d); checkEq("errSat", d, 16'h00FF);
    expErr = 0; expErrFlag = 1'b0;

`ifdef QDEC_GLITCH_FILTER_EN
    pre = irqSeen;
    @(posedge clk); chA = ~chA;
    repeat (3) @(posedge clk);
    chA = ~chA;
    repeat (LAT + 4) @(posedge clk);
    #1;
    checkEq("shortPulseIrq", irqSeen - pre, 0);
    pre = irqSeen;
    begin
      int firstLow = 0;
      @(posedge clk); chA = ~chA;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk);
        if (k == 5) chA = ~chA;
        #1;
        if (!irq_n && firstLow == 0) firstLow = k;
      end
      checkEq("pulseLatency", firstLow, LAT);
    end
    checkEq("longPulseIrq", irqSeen - pre, 2);
    busAccess(BASE + 12'd0, 0, d); checkEq("pulsePos", d, expPos);
`endif

    // reset in the middle of an access
    @(posedge clk);
    bus.add = BASE;
    bus.strobe = 1'b0;
    @(posedge clk); #1;
    checkEq("midReadyLow", bus.ready, 1'b0);
    rst_n = 1'b0;
    #1;
    checkEq("midRstReady", bus.ready, 1'b1);
    checkEq("midRstOe", bus.data_oe, 1'b0);
    bus.strobe = 1'b1;
    bus.add = 12'h000;
    expPos = 16'd0; expDir = 1'b0; expErr = 0; expErrFlag = 1'b0; expMoving = 1'b0;
    @(posedge clk);
    rst_n = 1'b1;
    pre = irqSeen;
    repeat (10) @(posedge clk);
    #1;
    checkEq("reprimeIrq", irqSeen - pre, 0);
    busAccess(BASE + 12'd1, 0, d); checkEq("reprimeStat", d, statusExp());
    encStep(1);
    busAccess(BASE + 12'd0, 0, d); checkEq("postRstPos", d, expPos);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
